// File: rtl/vga_capture.sv
// vga_capture: locks onto an incoming VGA raster, regenerates pixel coordinates, measures geometry and checksums frames
module vga_capture #(
    parameter int H_START         = 144,
    parameter int H_ACTIVE        = 640,
    parameter int V_START         = 35,
    parameter int V_ACTIVE        = 480,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    input  logic        hs,
    input  logic        vs,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [11:0] px_rgb,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum
);
    typedef enum logic [1:0] {ACQUIRE, CHECK, LOCKED} state_e;

    localparam logic [10:0] H_LO  = 11'(H_START);
    localparam logic [10:0] H_HI  = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  H_OFF = 10'(H_START);
    localparam logic [9:0]  V_LO  = 10'(V_START);
    localparam logic [9:0]  V_HI  = 10'(V_START + V_ACTIVE);

    state_e      state_q, state_d;
    logic        seed_q, seed_d;
    logic [11:0] rgb_q;
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic        hs_e, vs_e, sat, mismatch, win;
    logic [10:0] hpos_q, hpos_d, line_len_q, line_len_d;
    logic [9:0]  vline_q, vline_d, vline_inc, frame_lines_q, frame_lines_d;
    logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d;
    logic        frame_done_q, frame_done_d;
    logic        px_valid_q, px_valid_d;
    logic [9:0]  px_x_q, px_x_d, px_y_q, px_y_d;
    logic [11:0] px_rgb_q, px_rgb_d;

    // Edge detection, raster counters, geometry measurement, checksum and next pixel outputs
    always_comb begin
        hs_e          = hs_q & ~hs_prev_q;
        vs_e          = vs_q & ~vs_prev_q;
        hpos_d        = hs_e ? 11'd0 : (&hpos_q) ? hpos_q : hpos_q + 11'd1;
        line_len_d    = hs_e ? ((&hpos_q) ? 11'd0 : hpos_q + 11'd1) : line_len_q;
        vline_inc     = (hs_e && !(&vline_q)) ? vline_q + 10'd1 : vline_q;
        vline_d       = vs_e ? 10'd0 : vline_inc;
        frame_lines_d = vs_e ? vline_inc : frame_lines_q;
        sat           = (&hpos_q) | (&vline_q);
        mismatch      = (hs_e && line_len_d != line_len_q) || (vs_e && frame_lines_d != frame_lines_q);
        win           = hpos_d >= H_LO && hpos_d < H_HI && vline_d >= V_LO && vline_d < V_HI;
        acc_d         = vs_e ? 16'd0 : acc_q + (win ? {4'd0, rgb_q} : 16'd0);
        frame_done_d  = vs_e && state_q == LOCKED;
        frame_sum_d   = frame_done_d ? acc_q : frame_sum_q;
        px_valid_d    = win && state_d == LOCKED;
        px_x_d        = px_valid_d ? hpos_d[9:0] - H_OFF : 10'd0;
        px_y_d        = px_valid_d ? vline_d - V_LO : 10'd0;
        px_rgb_d      = px_valid_d ? rgb_q : 12'd0;
    end

    // Lock FSM: first frame after acquire seeds references, one matching frame locks
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        if (state_q == ACQUIRE) begin
            if (vs_e) begin
                state_d = CHECK;
                seed_d  = 1'b0;
            end
        end else if (sat || ((state_q == LOCKED || seed_q) && mismatch)) begin
            state_d = ACQUIRE;
        end else if (state_q == CHECK && vs_e) begin
            state_d = seed_q ? LOCKED : CHECK;
            seed_d  = 1'b1;
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACQUIRE;
            seed_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
        end
    end

    // Input stage, counters, measurements, checksum and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q         <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hpos_q        <= '0;
            vline_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            acc_q         <= '0;
            frame_sum_q   <= '0;
            frame_done_q  <= 1'b0;
            px_valid_q    <= 1'b0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            px_rgb_q      <= '0;
        end else begin
            rgb_q         <= {r, g, b};
            hs_q          <= hs ^ SYNC_ACTIVE_LOW;
            vs_q          <= vs ^ SYNC_ACTIVE_LOW;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            hpos_q        <= hpos_d;
            vline_q       <= vline_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            acc_q         <= acc_d;
            frame_sum_q   <= frame_sum_d;
            frame_done_q  <= frame_done_d;
            px_valid_q    <= px_valid_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
            px_rgb_q      <= px_rgb_d;
        end
    end

    assign locked      = state_q == LOCKED;
    assign px_valid    = px_valid_q;
    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign px_rgb      = px_rgb_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_done  = frame_done_q;
    assign frame_sum   = frame_sum_q;
endmodule
